// File: rtl/decoder24_rr_arbiter.sv
// Four-client round-robin arbiter with a registered, active-low one-hot grant bus.
// Define ARB_TIMEOUT_EN to preempt a grantee after MAX_HOLD cycles when another client waits.
module decoder24_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_n,
  input  logic [3:0] req,
  output logic [3:0] gnt_n,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CW) <= MAX_HOLD) begin : g_bad_params
    $error("decoder24_rr_arbiter: MAX_HOLD must be 2..255 and fit in CW bits");
  end

  function automatic logic [3:0] decode_n(input logic [1:0] idx);
    logic [3:0] bus;
    bus      = 4'b1111;
    bus[idx] = 1'b0;
    return bus;
  endfunction

  // Scan from the far end back toward ptr so the requester closest to ptr wins.
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        winner = ptr + 2'(k);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_cnt;
  logic          others_req;

  assign others_req = |(req & decode_n(gnt_idx));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_n     <= 4'b1111;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      ptr       <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!en_n && (req != 4'b0000)) begin
            state     <= GRANT;
            gnt_idx   <= winner;
            gnt_n     <= decode_n(winner);
            gnt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          // A release wins over a simultaneous disable so the pointer still advances.
          if (!req[gnt_idx]) begin
            state     <= IDLE;
            gnt_n     <= 4'b1111;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
          end else if (en_n) begin
            state     <= IDLE;
            gnt_n     <= 4'b1111;
            gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          end else if (hold_cnt == HOLD_LAST && others_req) begin
            state     <= IDLE;
            gnt_n     <= 4'b1111;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt  <= hold_cnt + CW'(1);
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder24_rr_arbiter.sv
// Self-checking bench for decoder24_rr_arbiter: directed literal checks plus random traffic
// compared every cycle against a behavioural round-robin model.
module tb_decoder24_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CW       = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_n  = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt_n;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  bit m_known = 1'b0;
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_held  = 0;

  decoder24_rr_arbiter #(
    .MAX_HOLD(MAX_HOLD),
    .CW      (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_n     (en_n),
    .req      (req),
    .gnt_n    (gnt_n),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] want);
    n_compared++;
    if (act !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] q);
    @(negedge clk);
    rst_n = r;
    en_n  = e;
    req   = q;
  endtask

  // Hand-computed expectation for the outputs right after the coming rising edge.
  task automatic checkLit(input string name, input logic [3:0] want_n, input logic [1:0] want_idx,
                          input logic want_valid);
    @(posedge clk);
    #1;
    checkOutput({name, ".gnt_n"}, gnt_n, want_n);
    checkOutput({name, ".gnt_idx"}, {2'b00, gnt_idx}, {2'b00, want_idx});
    checkOutput({name, ".gnt_valid"}, {3'b000, gnt_valid}, {3'b000, want_valid});
  endtask

  // Behavioural model: m_held counts granted cycles of the current owner.
  always @(posedge clk) begin : ref_model
    int o, p, h;
    bit b;
    o = m_owner;
    p = m_ptr;
    h = m_held;
    b = m_busy;
    if (!rst_n) begin
      b = 1'b0;
      o = 0;
      p = 0;
      h = 0;
      m_known <= 1'b1;
    end else if (!b) begin
      if (!en_n && req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (!b && req[(p + k) % 4]) begin
            o = (p + k) % 4;
            b = 1'b1;
            h = 1;
          end
        end
      end
    end else if (!req[o]) begin
      b = 1'b0;
      p = (o + 1) % 4;
    end else if (en_n) begin
      b = 1'b0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (h >= MAX_HOLD && (req & ~(4'd1 << o)) != 4'd0) begin
        b = 1'b0;
        p = (o + 1) % 4;
      end else begin
        h++;
      end
`else
      h++;
`endif
    end
    m_owner <= o;
    m_ptr   <= p;
    m_held  <= h;
    m_busy  <= b;
  end

  always @(negedge clk) begin
    if (m_known) begin
      checkOutput("model.gnt_n", gnt_n, m_busy ? (4'hF ^ (4'd1 << m_owner)) : 4'hF);
      checkOutput("model.gnt_idx", {2'b00, gnt_idx}, 4'(m_owner));
      checkOutput("model.gnt_valid", {3'b000, gnt_valid}, {3'b000, m_busy});
    end
  end

  initial begin
    logic [3:0] cur_req;
    logic [1:0] c;

    // Reset holds everything off even with all clients requesting.
    applyStimulus(1'b0, 1'b0, 4'b1111);
    checkLit("reset0", 4'b1111, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b1111);
    checkLit("reset1", 4'b1111, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1111);
    checkLit("post_reset", 4'b1110, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkLit("release0", 4'b1111, 2'd0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0100);
      checkLit("single", 4'b1011, 2'd2, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkLit("single_rel", 4'b1111, 2'd2, 1'b0);

    // Pointer is 3 here: client 0 must beat client 1.
    applyStimulus(1'b1, 1'b0, 4'b0011);
    checkLit("wrap_a", 4'b1110, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkLit("wrap_a_rel", 4'b1111, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0100);
    checkLit("to_ptr3", 4'b1011, 2'd2, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkLit("to_ptr3_rel", 4'b1111, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1001);
    checkLit("wrap_b", 4'b0111, 2'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkLit("wrap_b_rel", 4'b1111, 2'd3, 1'b0);

    for (int i = 0; i < 5; i++) begin
      c = 2'(i % 4);
      for (int j = 0; j < 3; j++) begin
        applyStimulus(1'b1, 1'b0, 4'b1111);
        checkLit("fair_grant", 4'hF ^ (4'd1 << c), c, 1'b1);
      end
      applyStimulus(1'b1, 1'b0, 4'hF ^ (4'd1 << c));
      checkLit("fair_idle", 4'b1111, c, 1'b0);
    end

    // Disabling mid-grant keeps the pointer, so client 1 wins again.
    applyStimulus(1'b1, 1'b0, 4'b0010);
    checkLit("en_grant", 4'b1101, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    checkLit("en_hold", 4'b1101, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0011);
    checkLit("en_drop", 4'b1111, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0011);
    checkLit("en_regrant", 4'b1101, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkLit("en_rel", 4'b1111, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1000);
    checkLit("to_ptr0", 4'b0111, 2'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkLit("to_ptr0_rel", 4'b1111, 2'd3, 1'b0);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0011);
`ifdef ARB_TIMEOUT_EN
      if (i <= 4) checkLit("timeout", 4'b1110, 2'd0, 1'b1);
      else if (i == 5) checkLit("timeout", 4'b1111, 2'd0, 1'b0);
      else checkLit("timeout", 4'b1101, 2'd1, 1'b1);
`else
      checkLit("hold_forever", 4'b1110, 2'd0, 1'b1);
`endif
    end
    applyStimulus(1'b1, 1'b0, 4'b0000);
`ifdef ARB_TIMEOUT_EN
    checkLit("timeout_rel", 4'b1111, 2'd1, 1'b0);
`else
    checkLit("hold_rel", 4'b1111, 2'd0, 1'b0);
`endif

    // Random traffic; requests change only now and then so grants get held.
    cur_req = 4'b0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom);
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0, cur_req);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
